// File: rtl/multicycle_control.sv
// Control FSM for the multicycle RV32I core: sequences fetch/decode/execute/memory/writeback.
// Optional JAL support is compiled in when the JAL_EN macro is defined.
module multicycle_control #(
  parameter int RET_CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           Opcode,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 Zero,
  input  logic                 MemReady,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 RegWrite,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ImmSrc,
  output logic [2:0]           ALUControl,
  output logic                 Illegal,
  output logic [RET_CNT_W-1:0] InstrRetired
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXER   = 4'd6;
  localparam logic [3:0] S_EXEI   = 4'd7;
  localparam logic [3:0] S_ALUWB  = 4'd8;
  localparam logic [3:0] S_BEQ    = 4'd9;
`ifdef JAL_EN
  localparam logic [3:0] S_JAL    = 4'd10;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
`endif

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  logic [3:0]           state_q, state_d;
  logic [RET_CNT_W-1:0] ret_q, ret_d;
  logic                 retire;

  // sub is only reachable from register-register ops; addi ignores funct7b5
  function automatic logic [2:0] alu_dec(input logic [2:0] f3, input logic f7, input logic is_r);
    case (f3)
      3'b000:  alu_dec = (is_r && f7) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_dec = ALU_SLT;
      3'b110:  alu_dec = ALU_OR;
      3'b111:  alu_dec = ALU_AND;
      default: alu_dec = ALU_ADD;
    endcase
  endfunction

  always_comb begin
    state_d      = state_q;
    retire       = 1'b0;
    PCWrite      = 1'b0;
    AdrSrc       = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    RegWrite     = 1'b0;
    ResultSrc    = 2'b00;
    ALUSrcA      = 2'b00;
    ALUSrcB      = 2'b00;
    ALUControl   = ALU_ADD;
    Illegal      = 1'b0;

    case (Opcode)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
`ifdef JAL_EN
      OP_JAL:  ImmSrc = 2'b11;
`endif
      default: ImmSrc = 2'b00;
    endcase

    case (state_q)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = MemReady;
        PCWrite   = MemReady;
        if (MemReady) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (Opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXER;
          OP_I:         state_d = S_EXEI;
          OP_BEQ:       state_d = S_BEQ;
`ifdef JAL_EN
          OP_JAL:       state_d = S_JAL;
`endif
          default: begin
            Illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        AdrSrc = 1'b1;
        if (MemReady) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWR: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (MemReady) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXER: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_dec(funct3, funct7b5, 1'b1);
        state_d    = S_ALUWB;
      end
      S_EXEI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_dec(funct3, funct7b5, 1'b0);
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA    = 2'b10;
        ALUControl = ALU_SUB;
        PCWrite    = Zero;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
`ifdef JAL_EN
      S_JAL: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        PCWrite  = 1'b1;
        RegWrite = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
`endif
      default: state_d = S_FETCH;
    endcase

    ret_d        = retire ? ret_q + RET_CNT_W'(1) : ret_q;
    InstrRetired = ret_q;

    // reset quiets every output, including the counter view, in the same cycle
    if (reset) begin
      state_d      = S_FETCH;
      ret_d        = '0;
      PCWrite      = 1'b0;
      AdrSrc       = 1'b0;
      MemWrite     = 1'b0;
      IRWrite      = 1'b0;
      RegWrite     = 1'b0;
      ResultSrc    = 2'b00;
      ALUSrcA      = 2'b00;
      ALUSrcB      = 2'b00;
      ImmSrc       = 2'b00;
      ALUControl   = ALU_ADD;
      Illegal      = 1'b0;
      InstrRetired = '0;
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    ret_q   <= ret_d;
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: an instruction-level model expands each
// instruction into its expected per-cycle control trace, which one loop drives and checks.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  Opcode = '0;
  logic [2:0]  funct3 = '0;
  logic        funct7b5 = 1'b0;
  logic        Zero = 1'b0;
  logic        MemReady = 1'b0;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0]  ALUControl;
  logic [31:0] InstrRetired;

  multicycle_control #(.RET_CNT_W(32)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .Illegal(Illegal), .InstrRetired(InstrRetired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic pcw, adr, memw, irw, regw;
    logic [1:0] res, sa, sb, imm;
    logic [2:0] alu;
    logic ill;
  } out_t;

  typedef struct {
    bit          rst, mr, z;
    logic [6:0]  op;
    logic [2:0]  f3;
    bit          f7;
    out_t        exp;
    logic [31:0] ret;
  } step_t;

  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_BEQ = 4, K_JAL = 5, K_ILL = 6;
`ifdef JAL_EN
  localparam bit JAL_ON = 1'b1;
`else
  localparam bit JAL_ON = 1'b0;
`endif

  step_t       q[$];
  int          errors = 0, checks = 0;
  logic [31:0] mcount = 0;
  logic [6:0]  cur_op;
  logic [2:0]  cur_f3;
  bit          cur_f7;

  function automatic logic [1:0] imm_of(input logic [6:0] op);
    if (op == 7'b0100011) return 2'b01;
    if (op == 7'b1100011) return 2'b10;
    if (op == 7'b1101111 && JAL_ON) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [2:0] alu_of(input logic [2:0] f3, input bit f7, input bit is_r);
    if (f3 == 3'b000) return (is_r && f7) ? 3'b001 : 3'b000;
    if (f3 == 3'b010) return 3'b101;
    if (f3 == 3'b110) return 3'b011;
    if (f3 == 3'b111) return 3'b010;
    return 3'b000;
  endfunction

  function automatic out_t o(bit pcw, bit adr, bit memw, bit irw, bit regw, logic [1:0] res,
                             logic [1:0] sa, logic [1:0] sb, logic [2:0] alu, bit ill);
    out_t r;
    r = '{pcw, adr, memw, irw, regw, res, sa, sb, 2'b00, alu, ill};
    return r;
  endfunction

  task automatic add_step(input bit mr, input bit z, input out_t e, input bit retire);
    step_t s;
    s.rst = 0; s.mr = mr; s.z = z; s.op = cur_op; s.f3 = cur_f3; s.f7 = cur_f7;
    e.imm = imm_of(cur_op);
    s.exp = e; s.ret = mcount;
    q.push_back(s);
    if (retire) mcount = mcount + 1;
  endtask

  task automatic add_reset();
    step_t s;
    s.rst = 1; s.mr = 1'($urandom); s.z = 1'($urandom);
    s.op = 7'($urandom); s.f3 = 3'($urandom); s.f7 = 1'($urandom);
    s.exp = '0; s.ret = 0;
    q.push_back(s);
    mcount = 0;
  endtask

  function automatic bit is_known(input logic [6:0] op);
    return op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
  endfunction

  // cut >= 0 replaces that cycle of the instruction (and the rest) by a reset cycle
  task automatic add_instr(input int kind, input int fw, input int mw, input bit z, input int cut);
    int start;
    bit ill;
    start = q.size();
    cur_f3 = 3'($urandom); cur_f7 = 1'($urandom);
    case (kind)
      K_LW:  cur_op = 7'b0000011;
      K_SW:  cur_op = 7'b0100011;
      K_R:   cur_op = 7'b0110011;
      K_I:   cur_op = 7'b0010011;
      K_BEQ: cur_op = 7'b1100011;
      K_JAL: cur_op = 7'b1101111;
      default: begin
        cur_op = 7'($urandom);
        while (is_known(cur_op)) cur_op = 7'($urandom);
      end
    endcase
    ill = (kind == K_ILL) || (kind == K_JAL && !JAL_ON);
    repeat (fw) add_step(0, 1'($urandom), o(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,0), 0);
    add_step(1, 1'($urandom), o(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,0), 0);
    add_step(1'($urandom), 1'($urandom), o(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,ill), 0);
    if (!ill) begin
      case (kind)
        K_LW, K_SW: begin
          add_step(1'($urandom), 1'($urandom), o(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,0), 0);
          repeat (mw) add_step(0, 1'($urandom), o(0,1,kind==K_SW,0,0,2'b00,2'b00,2'b00,3'b000,0), 0);
          add_step(1, 1'($urandom), o(0,1,kind==K_SW,0,0,2'b00,2'b00,2'b00,3'b000,0), kind == K_SW);
          if (kind == K_LW)
            add_step(1'($urandom), 1'($urandom), o(0,0,0,0,1,2'b01,2'b00,2'b00,3'b000,0), 1);
        end
        K_R, K_I: begin
          add_step(1'($urandom), 1'($urandom),
                   o(0,0,0,0,0,2'b00,2'b10,(kind == K_I) ? 2'b01 : 2'b00,
                     alu_of(cur_f3, cur_f7, kind == K_R),0), 0);
          add_step(1'($urandom), 1'($urandom), o(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,0), 1);
        end
        K_BEQ: add_step(1'($urandom), z, o(z,0,0,0,0,2'b00,2'b10,2'b00,3'b001,0), 1);
        default: add_step(1'($urandom), 1'($urandom), o(1,0,0,0,1,2'b00,2'b01,2'b10,3'b000,0), 1);
      endcase
    end
    if (cut >= 0 && start + cut < q.size()) begin
      while (q.size() > start + cut) void'(q.pop_back());
      add_reset();
    end
  endtask

  task automatic run_queue();
    step_t s;
    out_t  act;
    while (q.size() > 0) begin
      s = q.pop_front();
      @(negedge clk);
      reset = s.rst; MemReady = s.mr; Zero = s.z;
      Opcode = s.op; funct3 = s.f3; funct7b5 = s.f7;
      #1;
      act = '{PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
              ImmSrc, ALUControl, Illegal};
      checks++;
      if (act !== s.exp) begin
        errors++;
        $display("FAIL outputs t=%0t rst=%0d op=%b got=%h expected=%h", $time, s.rst, s.op, act, s.exp);
      end
      checks++;
      if (InstrRetired !== s.ret) begin
        errors++;
        $display("FAIL retired t=%0t got=%0d expected=%0d", $time, InstrRetired, s.ret);
      end
    end
  endtask

  task automatic check_len(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, got, want);
    end
  endtask

  initial begin
    int n, pulses;
    // two reset cycles
    add_reset(); add_reset();
    // lw with 3 fetch waits and 2 read waits
    n = q.size(); add_instr(K_LW, 3, 2, 0, -1);
    check_len("lw_cycles", q.size() - n, 10);
    pulses = 0;
    for (int i = n; i < q.size(); i++) pulses += q[i].exp.irw;
    check_len("lw_irwrite_pulses", pulses, 1);
    n = q.size(); add_instr(K_R, 0, 0, 0, -1);
    check_len("add_cycles", q.size() - n, 4);
    n = q.size(); add_instr(K_BEQ, 0, 0, 1, -1);
    check_len("beq_taken_cycles", q.size() - n, 3);
    check_len("beq_taken_pcwrite", q[q.size()-1].exp.pcw, 1);
    n = q.size(); add_instr(K_BEQ, 0, 0, 0, -1);
    check_len("beq_nt_pcwrite", q[q.size()-1].exp.pcw, 0);
    n = q.size(); add_instr(K_ILL, 0, 0, 0, -1);
    check_len("illegal_cycles", q.size() - n, 2);
    n = q.size(); add_instr(K_JAL, 0, 0, 0, -1);
    check_len("jal_cycles", q.size() - n, JAL_ON ? 3 : 2);
    run_queue();

    // a pinned sub: funct3=000 with funct7b5=1 in EXER
    @(negedge clk);
    reset = 0; MemReady = 1; Opcode = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
    @(negedge clk); MemReady = 0;   // DECODE
    @(negedge clk); #1;             // EXER
    check_len("sub_alucontrol", int'(ALUControl), 1);
    @(negedge clk); #1;             // ALUWB
    check_len("sub_regwrite", int'(RegWrite), 1);
    @(negedge clk); #1;             // back in FETCH, MemReady low
    check_len("retired_after_directed", int'(InstrRetired), JAL_ON ? 6 : 5);
    mcount = InstrRetired === (JAL_ON ? 32'd6 : 32'd5) ? InstrRetired : 32'd0;
    if (mcount == 0) add_reset();

    // randomized instruction stream with occasional mid-instruction reset
    for (int i = 0; i < 400; i++) begin
      int kind, cut;
      kind = $urandom_range(0, 6);
      cut  = ($urandom_range(0, 14) == 0) ? $urandom_range(0, 6) : -1;
      add_instr(kind, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), cut);
    end
    run_queue();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
